if_inference_ctrl: RTL and testbench

Run controller for the integrate-and-fire network. For each run it holds the network in reset between runs and drives a latched input spike pattern for a fixed number of timesteps. It counts the network's output spikes per output neuron and selects the winning class by sequential argmax. The result is returned over a valid/ready handshake. It sits between the host/stimulus logic and `if_network`, owning that network's `rst` and `spike_in` and observing its `spike_out`.

---
 rtl/if_inference_ctrl_if.sv | 33 +++
 rtl/if_inference_ctrl.sv | 160 ++++++++++++++++
 tb/tb_if_inference_ctrl.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_inference_ctrl_if.sv
// Signal bundle between the host, if_inference_ctrl and the network it drives.
// The controller connects through the slave modport; the host/network side uses master.
interface if_inference_ctrl_if #(
  parameter int NUM_INPUTS  = 4,
  parameter int NUM_OUTPUTS = 4,
  parameter int CNT_WIDTH   = 8
);
  localparam int CLS_W = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;

  logic                   start;
  logic [NUM_INPUTS-1:0]  in_pattern;
  logic                   busy;
  logic                   net_rst;
  logic [NUM_INPUTS-1:0]  net_spike_in;
  logic [NUM_OUTPUTS-1:0] net_spike_out;
  logic                   result_valid;
  logic                   result_ready;
  logic [CLS_W-1:0]       result_class;
  logic [CNT_WIDTH-1:0]   result_count;
  logic                   result_none;

  modport master (
    output start, in_pattern, result_ready, net_spike_out,
    input  busy, net_rst, net_spike_in, result_valid,
           result_class, result_count, result_none
  );

  modport slave (
    input  start, in_pattern, result_ready, net_spike_out,
    output busy, net_rst, net_spike_in, result_valid,
           result_class, result_count, result_none
  );
endinterface

// File: rtl/if_inference_ctrl.sv
// Run controller for the integrate-and-fire network: drives a latched pattern for a fixed
// number of timesteps, counts output spikes per class and reports the argmax winner.
module if_inference_ctrl #(
  parameter int NUM_INPUTS  = 4,
  parameter int NUM_OUTPUTS = 4,
  parameter int NUM_STEPS   = 16,
  parameter int NET_LAT     = 1,
  parameter int CNT_WIDTH   = 8
) (
  input logic               clk,
  input logic               rst,
  if_inference_ctrl_if.slave bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RUN    = 3'd1;
  localparam logic [2:0] S_DRAIN  = 3'd2;
  localparam logic [2:0] S_DECIDE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam int CLS_W   = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;
  localparam int MAX_A   = (NUM_STEPS > NET_LAT) ? NUM_STEPS : NET_LAT;
  localparam int MAX_CNT = (MAX_A > NUM_OUTPUTS) ? MAX_A : NUM_OUTPUTS;
  localparam int STEP_W  = $clog2(MAX_CNT + 1);

  localparam logic [STEP_W-1:0] RUN_LAST   = STEP_W'(NUM_STEPS - 1);
  localparam logic [STEP_W-1:0] DRAIN_LAST = STEP_W'((NET_LAT > 0) ? NET_LAT - 1 : 0);
  localparam logic [STEP_W-1:0] DEC_LAST   = STEP_W'(NUM_OUTPUTS - 1);

  logic [2:0]            state_q,   state_d;
  logic [STEP_W-1:0]     step_q,    step_d;
  logic [NUM_INPUTS-1:0] pattern_q, pattern_d;
  logic [CNT_WIDTH-1:0]  best_q,    best_d;
  logic [CLS_W-1:0]      class_q,   class_d;
  logic                  none_q,    none_d;
  logic [CNT_WIDTH-1:0]  cnt_q [NUM_OUTPUTS];
  logic                  cnt_clr;
  logic                  cnt_en;
  logic [CNT_WIDTH-1:0]  cand;

  // DECIDE walks the counters with the shared step counter as the index.
  assign cand = cnt_q[step_q[CLS_W-1:0]];

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d   = state_q;
    step_d    = step_q;
    pattern_d = pattern_q;
    best_d    = best_q;
    class_d   = class_q;
    none_d    = none_q;
    cnt_clr   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          pattern_d = bus.in_pattern;
          step_d    = '0;
          best_d    = '0;
          class_d   = '0;
          none_d    = 1'b0;
          cnt_clr   = 1'b1;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        if (step_q == RUN_LAST) begin
          step_d  = '0;
          state_d = (NET_LAT == 0) ? S_DECIDE : S_DRAIN;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (step_q == DRAIN_LAST) begin
          step_d  = '0;
          state_d = S_DECIDE;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      S_DECIDE: begin
        // Strictly-greater replacement keeps ties on the lowest index.
        if (cand > best_q) begin
          best_d  = cand;
          class_d = step_q[CLS_W-1:0];
        end
        if (step_q == DEC_LAST) begin
          step_d  = '0;
          none_d  = (best_d == '0);
          state_d = S_DONE;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      S_DONE: begin
        if (bus.result_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      step_q    <= '0;
      pattern_q <= '0;
      best_q    <= '0;
      class_q   <= '0;
      none_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values,
      // independent of statement order.
      state_q   <= state_d;
      step_q    <= step_d;
      pattern_q <= pattern_d;
      best_q    <= best_d;
      class_q   <= class_d;
      none_q    <= none_d;
    end
  end

  // Count window is RUN delayed by the network latency, so it lines up with spike_out.
  generate
    if (NET_LAT == 0) begin : g_no_lat
      assign cnt_en = (state_q == S_RUN);
    end else begin : g_lat
      logic [NET_LAT-1:0] run_dly_q;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) run_dly_q <= '0;
        else      run_dly_q <= (run_dly_q << 1) | NET_LAT'(state_q == S_RUN);
      end
      assign cnt_en = run_dly_q[NET_LAT-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the counter array is reset explicitly; an aborted run must not leak
      // partial counts into the next decision.
      for (int j = 0; j < NUM_OUTPUTS; j++) cnt_q[j] <= '0;
    end else if (cnt_clr) begin
      for (int j = 0; j < NUM_OUTPUTS; j++) cnt_q[j] <= '0;
    end else if (cnt_en) begin
      for (int j = 0; j < NUM_OUTPUTS; j++) begin
        if (bus.net_spike_out[j] && (cnt_q[j] != '1)) cnt_q[j] <= cnt_q[j] + 1'b1;
      end
    end
  end

  assign bus.busy         = (state_q != S_IDLE);
  assign bus.net_rst      = (state_q != S_RUN) && (state_q != S_DRAIN);
  assign bus.net_spike_in = (state_q == S_RUN) ? pattern_q : '0;
  assign bus.result_valid = (state_q == S_DONE);
  assign bus.result_class = class_q;
  assign bus.result_count = best_q;
  assign bus.result_none  = none_q;

endmodule

// File: tb/tb_if_inference_ctrl.sv
// Bench for if_inference_ctrl: default instance plus a saturating zero-latency instance,
// each with a behavioural network model and a per-output spike override.
module tb_if_inference_ctrl;

  localparam int NO    = 4;
  localparam int NS_A  = 16;
  localparam int NL_A  = 1;
  localparam int NS_B  = 20;
  localparam int NL_B  = 0;
  localparam int LAT_A = NS_A + NL_A + NO;
  localparam int LAT_B = NS_B + NL_B + NO;

  typedef struct packed {
    logic       busy;
    logic       net_rst;
    logic       valid;
    logic       none;
    logic [1:0] cls;
    logic [7:0] cnt;
    logic [3:0] spk;
  } obs_t;

  typedef struct packed {
    logic [1:0] cls;
    logic [7:0] cnt;
    logic       none;
  } exp_t;

  typedef struct {
    int         d;
    logic [3:0] pat;
    exp_t       e;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start_v  [2];
  logic [3:0] pat_v    [2];
  logic       ready_v  [2];
  logic [3:0] ovr_mask [2];
  logic [3:0] ovr_val  [2];

  if_inference_ctrl_if #(.NUM_INPUTS(4), .NUM_OUTPUTS(NO), .CNT_WIDTH(8)) a_if ();
  if_inference_ctrl_if #(.NUM_INPUTS(4), .NUM_OUTPUTS(NO), .CNT_WIDTH(3)) b_if ();

  if_inference_ctrl #(
    .NUM_INPUTS(4), .NUM_OUTPUTS(NO), .NUM_STEPS(NS_A), .NET_LAT(NL_A), .CNT_WIDTH(8)
  ) u_dut (.clk(clk), .rst(rst), .bus(a_if.slave));

  if_inference_ctrl #(
    .NUM_INPUTS(4), .NUM_OUTPUTS(NO), .NUM_STEPS(NS_B), .NET_LAT(NL_B), .CNT_WIDTH(3)
  ) u_sat (.clk(clk), .rst(rst), .bus(b_if.slave));

  assign a_if.start        = start_v[0];
  assign a_if.in_pattern   = pat_v[0];
  assign a_if.result_ready = ready_v[0];
  assign b_if.start        = start_v[1];
  assign b_if.in_pattern   = pat_v[1];
  assign b_if.result_ready = ready_v[1];

  // Network models: spike_out is spike_in delayed NET_LAT cycles, with masked override.
  logic [3:0] net_a_q;
  always @(posedge clk or negedge rst) begin
    if (!rst) net_a_q <= '0;
    else      net_a_q <= a_if.net_spike_in;
  end
  assign a_if.net_spike_out = (net_a_q & ~ovr_mask[0]) | (ovr_val[0] & ovr_mask[0]);
  assign b_if.net_spike_out = (b_if.net_spike_in & ~ovr_mask[1]) | (ovr_val[1] & ovr_mask[1]);

  int   n_pass  = 0;
  int   n_total = 0;
  exp_t sb_q[$];
  vec_t vecs[16];
  int   nv = 0;
  obs_t rst_obs;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic obs_t get_obs(input int d);
    obs_t o;
    if (d == 0) begin
      o.busy = a_if.busy;  o.net_rst = a_if.net_rst; o.valid = a_if.result_valid;
      o.none = a_if.result_none; o.cls = a_if.result_class; o.cnt = a_if.result_count;
      o.spk  = a_if.net_spike_in;
    end else begin
      o.busy = b_if.busy;  o.net_rst = b_if.net_rst; o.valid = b_if.result_valid;
      o.none = b_if.result_none; o.cls = b_if.result_class; o.cnt = {5'b0, b_if.result_count};
      o.spk  = b_if.net_spike_in;
    end
    return o;
  endfunction

  task automatic add_vec(input int d, input logic [3:0] pat, input logic [1:0] cls,
                         input logic [7:0] cnt, input logic none);
    vecs[nv].d = d;
    vecs[nv].pat = pat;
    vecs[nv].e.cls = cls;
    vecs[nv].e.cnt = cnt;
    vecs[nv].e.none = none;
    nv++;
  endtask

  // Called just after a rising edge; the start is accepted on the next edge (E0).
  task automatic start_run(input int d, input logic [3:0] pat, input bit push, input exp_t e);
    if (push) sb_q.push_back(e);
    start_v[d] = 1'b1;
    pat_v[d]   = pat;
    @(posedge clk); #1;
    start_v[d] = 1'b0;
    pat_v[d]   = ~pat;
  endtask

  // k0 = negedges after E0 already consumed by the caller.
  task automatic wait_result(input int d, input int k0, input logic [3:0] pat,
                             input int hold, input string name);
    int   lat, ns, nl, k, n_drv, n_run;
    bit   found;
    obs_t o, o0;
    exp_t e;
    lat = (d == 0) ? LAT_A : LAT_B;
    ns  = (d == 0) ? NS_A : NS_B;
    nl  = (d == 0) ? NL_A : NL_B;
    k = k0; found = 0; n_drv = 0; n_run = 0;
    o = get_obs(d);
    while (!found && k < 200) begin
      @(negedge clk);
      o = get_obs(d);
      if (k == 0) check($sformatf("%s busy/net_rst after start", name), {o.busy, o.net_rst}, 2'b10);
      if (o.valid) found = 1;
      else begin
        if (o.spk == pat) n_drv++;
        if (!o.net_rst) n_run++;
        k++;
      end
    end
    check($sformatf("%s result_valid seen", name), found, 1);
    if (!found) begin
      @(posedge clk); #1;
      return;
    end
    check($sformatf("%s latency", name), k, lat);
    if (k0 == 0) begin
      check($sformatf("%s net_rst low cycles", name), n_run, ns + nl);
      if (pat != 4'b0000) check($sformatf("%s pattern drive cycles", name), n_drv, ns);
    end
    if (sb_q.size() == 0) begin
      check($sformatf("%s scoreboard empty", name), 0, 1);
    end else begin
      e = sb_q.pop_front();
      check($sformatf("%s class", name), o.cls, e.cls);
      check($sformatf("%s count", name), o.cnt, e.cnt);
      check($sformatf("%s none", name), o.none, e.none);
    end
    if (hold > 0) begin
      o0 = o;
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        start_v[d] = (h == 3);
        pat_v[d]   = 4'b1111;
        @(negedge clk);
        check($sformatf("%s hold cycle %0d", name, h), get_obs(d), o0);
      end
      @(posedge clk); #1;
      start_v[d] = 1'b0;
      ready_v[d] = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    o = get_obs(d);
    check($sformatf("%s busy/valid after accept", name), {o.busy, o.valid}, 2'b00);
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    obs_t o;
    exp_t e;
    bit   bad;

    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      start_v[d] = 1'b0; pat_v[d] = '0; ready_v[d] = 1'b1;
      ovr_mask[d] = '0;  ovr_val[d] = '0;
    end
    rst_obs = '0;
    rst_obs.net_rst = 1'b1;

    add_vec(0, 4'b0100, 2'd2, 8'd16, 1'b0);
    add_vec(0, 4'b1010, 2'd1, 8'd16, 1'b0);
    add_vec(0, 4'b0000, 2'd0, 8'd0,  1'b1);
    add_vec(0, 4'b1111, 2'd0, 8'd16, 1'b0);
    add_vec(0, 4'b1000, 2'd3, 8'd16, 1'b0);
    add_vec(1, 4'b0001, 2'd0, 8'd7,  1'b0);
    add_vec(1, 4'b0100, 2'd2, 8'd7,  1'b0);
    add_vec(1, 4'b0000, 2'd0, 8'd0,  1'b1);
    add_vec(1, 4'b1100, 2'd2, 8'd7,  1'b0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset outputs dut", get_obs(0), rst_obs);
    check("reset outputs sat", get_obs(1), rst_obs);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < nv; i++) begin
      start_run(vecs[i].d, vecs[i].pat, 1, vecs[i].e);
      wait_result(vecs[i].d, 0, vecs[i].pat, 0, $sformatf("vec%0d", i));
    end

    // Override: output 0 gets 5 spikes, output 3 gets 6 inside the window; spikes outside ignored.
    ovr_mask[0] = 4'b1111; ovr_val[0] = 4'b1111;
    @(posedge clk); #1;
    ovr_mask[0] = 4'b1001;
    e.cls = 2'd3; e.cnt = 8'd6; e.none = 1'b0;
    start_run(0, 4'b0000, 1, e);
    for (int m = 0; m < 18; m++) begin
      ovr_val[0] = (m == 0 || m == 17) ? 4'b1111 : {m <= 6, 2'b00, m <= 5};
      @(posedge clk); #1;
    end
    ovr_mask[0] = '0; ovr_val[0] = '0;
    wait_result(0, 18, 4'b0000, 0, "override");

    // Zero-latency instance: spikes before RUN and after RUN must not count.
    ovr_mask[1] = 4'b1111; ovr_val[1] = 4'b1111;
    e.cls = 2'd0; e.cnt = 8'd0; e.none = 1'b1;
    start_run(1, 4'b0000, 1, e);
    for (int m = 0; m < 22; m++) begin
      ovr_val[1] = (m >= 20) ? 4'b1111 : 4'b0000;
      @(posedge clk); #1;
    end
    ovr_mask[1] = '0; ovr_val[1] = '0;
    wait_result(1, 22, 4'b0000, 0, "late spikes");

    // Reset mid-RUN aborts the run with no result.
    e = '0;
    start_run(0, 4'b0100, 0, e);
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1;
    check("reset mid-run outputs", get_obs(0), rst_obs);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      o = get_obs(0);
      if (o.valid || o.busy) bad = 1;
    end
    check("no result after abort", bad, 0);
    check("idle outputs after abort", get_obs(0), rst_obs);
    @(posedge clk); #1;

    // Backpressure with an ignored start pulse during the hold.
    ready_v[0] = 1'b0;
    e.cls = 2'd1; e.cnt = 8'd16; e.none = 1'b0;
    start_run(0, 4'b0110, 1, e);
    wait_result(0, 0, 4'b0110, 10, "backpressure");
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (get_obs(0).busy) bad = 1;
    end
    check("start during hold not queued", bad, 0);
    check("scoreboard drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
